// File: rtl/bundle_packer.sv
`default_nettype none
// ============================================================================
// Module   : bundle_packer
// Brief    : Packs in-order 16-bit ops into a 32-bit dual-slot IR word
//            (ALU -> IR[15:0], memory/control -> IR[31:16]).
// Revision : 1.0
// ============================================================================
module bundle_packer #(
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ir,
    output logic             illegal,
    output logic [CNT_W-1:0] bundle_cnt,
    output logic [CNT_W-1:0] nop_fill_cnt
);

    localparam logic [7:0] TMAX = 8'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_pending;
    logic [7:0]  r_timer;

    logic        w_free;
    logic        w_accept;
    logic        w_is_alu;
    logic        w_is_s2;
    logic        w_is_nop;
    logic        w_is_ill;
    logic        w_emit;
    logic        w_nop_fill;
    logic [31:0] w_emit_ir;

    assign w_free   = ~out_valid | out_ready;
    assign in_ready = w_free & ~flush;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_is_alu = 1'b0;
        w_is_s2  = 1'b0;
        w_is_nop = 1'b0;
        case (in_op[4:0])
            5'b01000, 5'b00101:                     w_is_alu = 1'b1;
            5'b01010, 5'b01011, 5'b11110, 5'b11011: w_is_s2  = 1'b1;
            5'b00000:                               w_is_nop = 1'b1;
            default: ;
        endcase
    end

    assign w_is_ill = ~(w_is_alu | w_is_s2 | w_is_nop);

    // An illegal op counts as an accept but must not disturb the pending op,
    // so it falls into neither emit path below.
    always_comb begin
        w_emit     = 1'b0;
        w_nop_fill = 1'b0;
        w_emit_ir  = 32'h0;
        if (w_accept && !w_is_ill) begin
            if (r_state == PEND) begin
                w_emit = 1'b1;
                if (w_is_s2) begin
                    w_emit_ir = {in_op, r_pending};
                end else begin
                    w_emit_ir  = {16'h0000, r_pending};
                    w_nop_fill = 1'b1;
                end
            end else if (w_is_s2) begin
                w_emit     = 1'b1;
                w_emit_ir  = {in_op, 16'h0000};
                w_nop_fill = 1'b1;
            end
        end else if (!w_accept && r_state == PEND && w_free &&
                     (r_timer == TMAX || flush)) begin
            w_emit     = 1'b1;
            w_emit_ir  = {16'h0000, r_pending};
            w_nop_fill = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pending    <= 16'h0000;
            r_timer      <= 8'd0;
            out_valid    <= 1'b0;
            out_ir       <= 32'h0;
            illegal      <= 1'b0;
            bundle_cnt   <= '0;
            nop_fill_cnt <= '0;
        end else begin
            illegal <= w_accept & w_is_ill;

            if (w_emit) begin
                out_valid  <= 1'b1;
                out_ir     <= w_emit_ir;
                bundle_cnt <= bundle_cnt + CNT_W'(1);
                if (w_nop_fill) begin
                    nop_fill_cnt <= nop_fill_cnt + CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (w_accept && !w_is_ill) begin
                if (w_is_alu) begin
                    r_pending <= in_op;
                    r_timer   <= 8'd0;
                    r_state   <= PEND;
                end else begin
                    r_state <= IDLE;
                end
            end else if (r_state == PEND) begin
                if (w_emit) begin
                    r_state <= IDLE;
                end else if (r_timer != TMAX) begin
                    r_timer <= r_timer + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bundle_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bundle_packer
// Brief    : Directed scenarios plus randomized traffic against a packing model.
// Revision : 1.0
// ============================================================================
module tb_bundle_packer;

    localparam int FC = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic        illegal;
    logic [15:0] bundle_cnt;
    logic [15:0] nop_fill_cnt;

    int checks = 0;
    int errors = 0;
    bit rdy_seen;

    // Reference model state: an optional held ALU op and its idle age.
    bit          m_pend;
    logic [15:0] m_pend_op;
    int          m_age;
    bit          m_ov;
    logic [31:0] m_ir;
    bit          m_ill;
    logic [15:0] m_bcnt;
    logic [15:0] m_ncnt;

    bundle_packer #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ir       (out_ir),
        .illegal      (illegal),
        .bundle_cnt   (bundle_cnt),
        .nop_fill_cnt (nop_fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1 = ALU, 2 = slot-2 op, 0 = nop, 3 = illegal
    function automatic int op_class(input logic [4:0] opc);
        case (opc)
            5'h08, 5'h05:               return 1;
            5'h0A, 5'h0B, 5'h1E, 5'h1B: return 2;
            5'h00:                      return 0;
            default:                    return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_pend_op = '0; m_age = 0;
        m_ov = 0; m_ir = '0; m_ill = 0; m_bcnt = '0; m_ncnt = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit          free;
        bit          acc;
        bit          emit;
        bit          nopf;
        logic [31:0] eir;
        int          c;
        free = !m_ov || out_ready;
        acc  = in_valid && free && !flush;
        emit = 0; nopf = 0; eir = '0;
        m_ill = 0;
        c = op_class(in_op[4:0]);
        if (acc && c == 3) begin
            m_ill = 1;
            if (m_pend && m_age < FC - 1) m_age++;
        end else if (acc) begin
            if (m_pend) begin
                emit = 1;
                if (c == 2) eir = {in_op, m_pend_op};
                else begin eir = {16'h0, m_pend_op}; nopf = 1; end
            end else if (c == 2) begin
                emit = 1; eir = {in_op, 16'h0}; nopf = 1;
            end
            m_pend = (c == 1);
            if (c == 1) begin m_pend_op = in_op; m_age = 0; end
        end else if (m_pend) begin
            if ((m_age == FC - 1 || flush) && free) begin
                emit = 1; eir = {16'h0, m_pend_op}; nopf = 1; m_pend = 0;
            end else if (m_age < FC - 1) m_age++;
        end
        if (m_ov && out_ready) m_ov = 0;
        if (emit) begin
            m_ov = 1; m_ir = eir; m_bcnt++;
            if (nopf) m_ncnt++;
        end
    endtask

    task automatic cyc(input bit v, input logic [15:0] op, input bit f, input bit r);
        in_valid = v; in_op = op; flush = f; out_ready = r;
        #1;
        rdy_seen = in_ready;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; in_op = '0; flush = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", out_ir); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (bundle_cnt !== 16'h0 || nop_fill_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bundle_cnt, nop_fill_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_pair();
        do_reset();
        cyc(1, 16'h0088, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_hold: got valid %b want 0", out_valid); end
        cyc(1, 16'h004A, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_ir !== 32'h004A_0088) begin errors++; $display("FAIL pair_ir: got %b/%h want 1/004a0088", out_valid, out_ir); end
        checks++; if (bundle_cnt !== 16'd1 || nop_fill_cnt !== 16'd0) begin errors++; $display("FAIL pair_cnt: got %0d/%0d want 1/0", bundle_cnt, nop_fill_cnt); end
        cyc(0, 16'h0000, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_drain: got valid %b want 0", out_valid); end
    endtask

    task automatic test_two_alu();
        do_reset();
        cyc(1, 16'h0088, 0, 1);
        cyc(1, 16'h0005, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_ir !== 32'h0000_0088) begin errors++; $display("FAIL two_alu_first: got %b/%h want 1/00000088", out_valid, out_ir); end
        cyc(1, 16'h000B, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_ir !== 32'h000B_0005) begin errors++; $display("FAIL two_alu_second: got %b/%h want 1/000b0005", out_valid, out_ir); end
        checks++; if (nop_fill_cnt !== 16'd1 || bundle_cnt !== 16'd2) begin errors++; $display("FAIL two_alu_cnt: got %0d/%0d want 2/1", bundle_cnt, nop_fill_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(1, 16'h001E, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_ir !== 32'h001E_0000) begin errors++; $display("FAIL timeout_jump: got %b/%h want 1/001e0000", out_valid, out_ir); end
        cyc(1, 16'h0088, 0, 1);
        for (int i = 1; i < FC; i++) begin
            cyc(0, 16'h0000, 0, 1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout_early: cycle %0d got valid %b want 0", i, out_valid); end
        end
        cyc(0, 16'h0000, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_ir !== 32'h0000_0088) begin errors++; $display("FAIL timeout_issue: got %b/%h want 1/00000088", out_valid, out_ir); end
        checks++; if (nop_fill_cnt !== 16'd2) begin errors++; $display("FAIL timeout_nops: got %0d want 2", nop_fill_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        cyc(1, 16'h001E, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h0088, 0, 0);
            checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", rdy_seen); end
            checks++; if (out_valid !== 1'b1 || out_ir !== 32'h001E_0000) begin errors++; $display("FAIL stall_hold: got %b/%h want 1/001e0000", out_valid, out_ir); end
        end
        cyc(1, 16'h0088, 0, 1);
        checks++; if (rdy_seen !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got ready %b valid %b want 1/0", rdy_seen, out_valid); end
        for (int i = 1; i < FC; i++) cyc(0, 16'h0000, 0, 1);
        cyc(0, 16'h0000, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_ir !== 32'h0000_0088) begin errors++; $display("FAIL stall_issue: got %b/%h want 1/00000088", out_valid, out_ir); end
        cyc(0, 16'h0000, 0, 1);
        checks++; if (out_valid !== 1'b0 || bundle_cnt !== 16'd2) begin errors++; $display("FAIL stall_count: got valid %b cnt %0d want 0/2", out_valid, bundle_cnt); end
    endtask

    task automatic test_illegal();
        do_reset();
        cyc(1, 16'h0088, 0, 1);
        cyc(1, 16'h001F, 0, 1);
        checks++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got ill %b valid %b want 1/0", illegal, out_valid); end
        cyc(1, 16'h001B, 0, 1);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_width: got %b want 0", illegal); end
        checks++; if (out_valid !== 1'b1 || out_ir !== 32'h001B_0088) begin errors++; $display("FAIL illegal_ir: got %b/%h want 1/001b0088", out_valid, out_ir); end
    endtask

    task automatic test_flush();
        do_reset();
        cyc(1, 16'h0005, 0, 1);
        cyc(1, 16'h0088, 1, 1);
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", rdy_seen); end
        checks++; if (out_valid !== 1'b1 || out_ir !== 32'h0000_0005) begin errors++; $display("FAIL flush_ir: got %b/%h want 1/00000005", out_valid, out_ir); end
        cyc(0, 16'h0000, 0, 1);
        checks++; if (out_valid !== 1'b0 || bundle_cnt !== 16'd1) begin errors++; $display("FAIL flush_after: got valid %b cnt %0d want 0/1", out_valid, bundle_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1, 16'h0088, 0, 1);
        cyc(1, 16'h0005, 0, 0);
        #2;
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_ir !== 32'h0 || illegal !== 1'b0) begin errors++; $display("FAIL areset_out: got %b/%h/%b want 0/0/0", out_valid, out_ir, illegal); end
        checks++; if (bundle_cnt !== 16'h0 || nop_fill_cnt !== 16'h0) begin errors++; $display("FAIL areset_cnt: got %0d/%0d want 0/0", bundle_cnt, nop_fill_cnt); end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < FC + 2; i++) cyc(0, 16'h0000, 0, 1);
        checks++; if (out_valid !== 1'b0 || bundle_cnt !== 16'h0) begin errors++; $display("FAIL areset_discard: got valid %b cnt %0d want 0/0", out_valid, bundle_cnt); end
    endtask

    task automatic test_random();
        logic [4:0]  opcs [8];
        logic [15:0] op;
        bit          v, f, r, exp_rdy;
        opcs[0] = 5'h08; opcs[1] = 5'h05; opcs[2] = 5'h0A; opcs[3] = 5'h0B;
        opcs[4] = 5'h1E; opcs[5] = 5'h1B; opcs[6] = 5'h00; opcs[7] = 5'h1F;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 16'($urandom);
            op[4:0] = ($urandom_range(0, 15) == 0) ? 5'($urandom) : opcs[$urandom_range(0, 6)];
            f  = ($urandom_range(0, 11) == 0);
            r  = (n % 400 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            exp_rdy = (!m_ov || r) && !f;
            cyc(v, op, f, r);
            checks++; if (rdy_seen !== exp_rdy) begin errors++; $display("FAIL rnd_ready: n=%0d got %b want %b", n, rdy_seen, exp_rdy); end
            checks++; if (out_valid !== m_ov || (m_ov && out_ir !== m_ir)) begin errors++; $display("FAIL rnd_out: n=%0d got %b/%h want %b/%h", n, out_valid, out_ir, m_ov, m_ir); end
            checks++; if (illegal !== m_ill) begin errors++; $display("FAIL rnd_illegal: n=%0d got %b want %b", n, illegal, m_ill); end
            checks++; if (bundle_cnt !== m_bcnt || nop_fill_cnt !== m_ncnt) begin errors++; $display("FAIL rnd_cnt: n=%0d got %0d/%0d want %0d/%0d", n, bundle_cnt, nop_fill_cnt, m_bcnt, m_ncnt); end
        end
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_op = '0; flush = 0; out_ready = 1;
        model_reset();
        test_reset();
        test_pair();
        test_two_alu();
        test_timeout();
        test_stall();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bundle_packer.md
Name: bundle_packer

Overview:
- In-order issue-side packer that builds the 32-bit dual-slot instruction word consumed by the control decoder.
- Accepts one 16-bit operation per cycle in program order and places each one into the correct slot:
  - ALU ops go to slot 1, IR[15:0], opcode at IR[4:0].
  - Memory/control ops go to slot 2, IR[31:16], opcode at IR[20:16].
- Pairs an ALU op with the immediately following memory/control op when possible; otherwise fills the empty slot with nop (16'h0000).
- Sits between the instruction fetch buffer and the IR register.

Parameters:
- FLUSH_CYCLES, 4: idle cycles a pending ALU op waits for a partner before issuing alone (valid range 1..255).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_op is valid.
- in_ready  output  1  packer accepts in_op this cycle.
- in_op  input  16  operation; opcode = in_op[4:0].
- flush  input  1  force out any pending op; blocks input while high.
- out_valid  output  1  out_ir is valid.
- out_ready  input  1  downstream takes out_ir.
- out_ir  output  32  packed instruction word.
- illegal  output  1  one-cycle pulse: illegal opcode dropped.
- bundle_cnt  output  CNT_W  bundles issued, wraps.
- nop_fill_cnt  output  CNT_W  slots filled with nop, wraps.

Behaviour:
- Opcode classes:
  - ALU = 01000, 00101.
  - S2 = 01010 (load), 01011 (store), 11110 (jump), 11011 (branch).
  - NOP = 00000.
  - Every other opcode is illegal.
- Reset (async, rst_n=0):
  - state=IDLE, pending=0, timer=0.
  - out_valid=0, out_ir=0, illegal=0.
  - Both counters = 0.
  - Reset mid-operation discards any pending op and any undelivered bundle.
- Output register:
  - "Free" = ~out_valid | out_ready.
  - out_valid/out_ir hold stable until the bundle is accepted (out_valid & out_ready).
- in_ready = free & ~flush (combinational).
- Accept = in_valid & in_ready.
- Emit = load out_ir and set out_valid the next edge. Latency from accept to out_valid is 1 cycle.
- States are IDLE and PEND (one ALU op held in a 16-bit pending register).
- On accept:
  - IDLE, ALU: store it as pending, timer=0, go to PEND.
  - IDLE, S2: emit {in_op,16'h0000}, nop_fill_cnt+1, stay in IDLE.
  - IDLE, NOP: discard, no emit.
  - PEND, S2: emit {in_op,pending}, go to IDLE.
  - PEND, ALU: emit {16'h0000,pending}, nop_fill_cnt+1, store in_op as the new pending, timer=0, stay in PEND.
  - PEND, NOP: emit {16'h0000,pending}, nop_fill_cnt+1, go to IDLE.
  - Illegal (either state): drop the op, illegal=1 for one cycle, no state change. The timer keeps running.
- An S2 op never pairs with a later ALU op; program order is preserved.
- PEND with no accept this cycle:
  - If (timer==FLUSH_CYCLES-1 or flush) and free: emit {16'h0000,pending}, nop_fill_cnt+1, go to IDLE.
  - Otherwise timer increments, saturating at FLUSH_CYCLES-1. The op then issues as soon as the output register is free.
- flush in IDLE has no effect.
- bundle_cnt increments on every emit. Both counters wrap modulo 2^CNT_W.
- Only ALU ops occupy slot 1 and only S2 ops occupy slot 2; any other slot content is 16'h0000.

Test Plan:
- ALU 16'h0088 then load 16'h004A on consecutive cycles, out_ready=1:
  - out_ir=32'h004A_0088 one cycle after the load is accepted.
  - bundle_cnt=1, nop_fill_cnt=0.
- Two ALU ops 16'h0088, 16'h0005, then store 16'h000B:
  - Bundles are 32'h0000_0088 then 32'h000B_0005.
  - nop_fill_cnt=1.
- Jump 16'h001E from IDLE, then ALU 16'h0088 with no further input, FLUSH_CYCLES=4:
  - 32'h001E_0000 is emitted.
  - 32'h0000_0088 has out_valid rising 4 cycles after the ALU accept.
  - nop_fill_cnt=2.
- ALU 16'h0088 held with out_ready=0 and a prior bundle stalled:
  - in_ready=0.
  - The prior bundle stays stable.
  - After out_ready=1, the stalled bundle is accepted, then 32'h0000_0088 issues when the timeout is reached, with no loss or duplication.
- Op 16'h001F (illegal) between ALU 16'h0088 and branch 16'h001B:
  - illegal pulses for exactly 1 cycle.
  - Output is 32'h001B_0088.
- flush=1 while PEND with ALU 16'h0005:
  - in_ready=0.
  - 32'h0000_0005 is emitted next edge.
- Separately: assert rst_n=0 while PEND with out_valid=1.
  - All outputs and counters read 0 immediately, before the next clock edge.
